lsu_misalign_seq: RTL

//  Load/store sequencer between the execute stage and the byte-addressed data memory.

---
 rtl/lsu_misalign_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer between execute and a byte-addressed data memory; aligned accesses go out as one native access, misaligned half/word accesses as byte accesses.
// Latency from the accept edge to resp_valid_o: aligned 2 cycles, misaligned size+1 cycles, fault 1 cycle.
// Backpressure: req_ready_o is high only in IDLE, so one request is in flight at a time and request inputs are ignored while busy.
// Ports: clk_i/rst_i (sync, active-high); req_* request in; resp_* one-cycle completion;
//        dm_* registered memory interface; dm_rdata_i settles mid-cycle and is captured at the closing edge.
module lsu_misalign_seq #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [2:0]  dm_ctrl_o,
    output logic        dm_we_o,
    input  logic [31:0] dm_rdata_i
);

    typedef enum logic [2:0] {IDLE, SINGLE, BYTES, RESP, FAULT} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [2:0]  dm_ctrl_q, dm_ctrl_d;
    logic        dm_we_q, dm_we_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    // Request classification, evaluated on the raw inputs in IDLE.
    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_illegal, req_oor, req_aligned;

    always_comb begin
        case (req_funct3_i[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap back into range.
        req_end     = {1'b0, req_addr_i} + {30'b0, req_size};
        req_oor     = req_end > 33'(MEM_BYTES);
        req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                      (req_we_i && req_funct3_i[2]);
        req_aligned = (req_funct3_i[1:0] == 2'b00) ||
                      (req_funct3_i[1:0] == 2'b01 && !req_addr_i[0]) ||
                      (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] == 2'b00);
    end

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {{24{~f3[2] & v[7]}}, v[7:0]};
            2'b01:   return {{16{~f3[2] & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Index of the last byte in a split access: 1 for half, 3 for word.
    logic [1:0]  last_idx;
    logic [1:0]  cnt_nx;
    logic [31:0] buf_upd;
    assign last_idx = {funct3_q[1], funct3_q[1] | funct3_q[0]};
    assign cnt_nx   = cnt_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_ctrl_d    = dm_ctrl_q;
        dm_we_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = 32'd0;
        buf_upd      = buf_q;
        buf_upd[{cnt_q, 3'b000} +: 8] = dm_rdata_i[7:0];

        // The dm_*_d values describe the access of the cycle about to begin.
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    buf_d    = 32'd0;
                    cnt_d    = 2'd0;
                    if (req_illegal || req_oor) begin
                        state_d      = FAULT;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_aligned) begin
                        state_d    = SINGLE;
                        dm_addr_d  = req_addr_i;
                        dm_ctrl_d  = req_funct3_i;
                        dm_we_d    = req_we_i;
                        dm_wdata_d = req_wdata_i;
                    end else begin
                        state_d    = BYTES;
                        dm_addr_d  = req_addr_i;
                        dm_ctrl_d  = req_we_i ? 3'b000 : 3'b100;
                        dm_we_d    = req_we_i;
                        dm_wdata_d = {24'd0, req_wdata_i[7:0]};
                    end
                end
            end
            SINGLE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                if (!we_q) begin
                    buf_d        = dm_rdata_i;
                    resp_rdata_d = extend(dm_rdata_i, funct3_q);
                end
            end
            BYTES: begin
                if (!we_q) buf_d = buf_upd;
                if (cnt_q == last_idx) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (!we_q) resp_rdata_d = extend(buf_upd, funct3_q);
                end else begin
                    cnt_d      = cnt_nx;
                    dm_addr_d  = addr_q + {30'd0, cnt_nx};
                    dm_we_d    = we_q;
                    dm_wdata_d = {24'd0, wdata_q[{cnt_nx, 3'b000} +: 8]};
                end
            end
            default: state_d = IDLE;   // RESP and FAULT last one cycle
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= 2'd0;
            buf_q        <= 32'd0;
            dm_addr_q    <= 32'd0;
            dm_wdata_q   <= 32'd0;
            dm_ctrl_q    <= 3'b010;
            dm_we_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_ctrl_q    <= dm_ctrl_d;
            dm_we_q      <= dm_we_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_fault_o = resp_fault_q;
    assign resp_rdata_o = resp_rdata_q;
    assign dm_addr_o    = dm_addr_q;
    assign dm_wdata_o   = dm_wdata_q;
    assign dm_ctrl_o    = dm_ctrl_q;
    assign dm_we_o      = dm_we_q;

endmodule
